// File: rtl/msrv32_load_request_unit.sv
// Data-memory load request unit: issues word-aligned reads on the data bus.
// It waits for hready, then extracts and extends the addressed byte or halfword.
// It stalls the pipeline while the access is outstanding.
// It reports misaligned addresses, illegal load types and bus timeouts as one-cycle pulses.
module msrv32_load_request_unit #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        load_req_in,
    input  logic [31:0] iadder_in,
    input  logic [2:0]  funct3_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic        ms_riscv32_mp_dmrd_req_out,
    input  logic        ms_riscv32_mp_data_hready_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        load_busy_out,
    output logic        misaligned_load_out,
    output logic        access_fault_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Counter value at which a still-low hready turns into a timeout fault
    localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] w_addr_next;
    logic [2:0]  r_funct3;
    logic [2:0]  w_funct3_next;
    logic [7:0]  r_count;
    logic [7:0]  w_count_next;
    logic [31:0] r_load_data;
    logic [31:0] w_load_data_next;
    logic        r_misaligned;
    logic        w_misaligned_next;
    logic        r_fault;
    logic        w_fault_next;

    logic        w_illegal;
    logic        w_misaligned;
    logic [7:0]  w_byte_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_extended;

    // Split the bus word into its four byte lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign w_byte_lane[gi] = ms_riscv32_mp_dmdata_in[8*gi +: 8];
    end

    assign w_byte = w_byte_lane[r_addr[1:0]];
    assign w_half = r_addr[1] ? ms_riscv32_mp_dmdata_in[31:16]
                              : ms_riscv32_mp_dmdata_in[15:0];

    // Classify the incoming request; only meaningful while a request can be accepted
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (funct3_in)
            F3_LB, F3_LBU: w_misaligned = 1'b0;
            F3_LH, F3_LHU: w_misaligned = iadder_in[0];
            F3_LW:         w_misaligned = |iadder_in[1:0];
            default:       w_illegal    = 1'b1;
        endcase
    end

    // Extend the selected lane according to the latched load type
    always_comb begin
        w_extended = ms_riscv32_mp_dmdata_in;
        case (r_funct3)
            F3_LB:   w_extended = {{24{w_byte[7]}}, w_byte};
            F3_LH:   w_extended = {{16{w_half[15]}}, w_half};
            F3_LBU:  w_extended = {24'd0, w_byte};
            F3_LHU:  w_extended = {16'd0, w_half};
            default: w_extended = ms_riscv32_mp_dmdata_in;
        endcase
    end

    // Next-state logic: acceptance in IDLE/RESP, handshake and timeout in REQ
    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_funct3_next     = r_funct3;
        w_count_next      = r_count;
        w_load_data_next  = r_load_data;
        w_misaligned_next = 1'b0;
        w_fault_next      = 1'b0;
        case (r_state)
            REQ: begin
                if (ms_riscv32_mp_data_hready_in) begin
                    w_load_data_next = w_extended;
                    w_state_next     = RESP;
                end else if (r_count == CNT_LAST) begin
                    w_fault_next = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_count_next = r_count + 8'd1;
                end
            end
            default: begin
                // IDLE and RESP both accept a new request
                w_state_next = IDLE;
                if (load_req_in) begin
                    if (w_illegal) begin
                        w_fault_next = 1'b1;
                    end else if (w_misaligned) begin
                        w_misaligned_next = 1'b1;
                    end else begin
                        w_addr_next   = iadder_in;
                        w_funct3_next = funct3_in;
                        w_count_next  = 8'd0;
                        w_state_next  = REQ;
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state      <= IDLE;
            r_addr       <= 32'd0;
            r_funct3     <= 3'd0;
            r_count      <= 8'd0;
            r_load_data  <= 32'd0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_funct3     <= w_funct3_next;
            r_count      <= w_count_next;
            r_load_data  <= w_load_data_next;
            r_misaligned <= w_misaligned_next;
            r_fault      <= w_fault_next;
        end
    end

    // All outputs are decodes of registered state, so no input reaches them combinationally
    assign ms_riscv32_mp_dmaddr_out   = {r_addr[31:2], 2'b00};
    assign ms_riscv32_mp_dmrd_req_out = (r_state == REQ);
    assign load_busy_out              = (r_state == REQ);
    assign load_valid_out             = (r_state == RESP);
    assign load_data_out              = r_load_data;
    assign misaligned_load_out        = r_misaligned;
    assign access_fault_out           = r_fault;

endmodule

// File: tb/tb_msrv32_load_request_unit.sv
// Directed bench for msrv32_load_request_unit: table of single loads plus
// hand-written back-to-back and mid-request reset sequences.
module tb_msrv32_load_request_unit;

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_MIS   = 2;
    localparam int K_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [31:0] iadder = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] dmaddr;
    logic        dmrd_req;
    logic        hready = 1'b0;
    logic [31:0] dmdata = 32'd0;
    logic [31:0] load_data;
    logic        valid;
    logic        busy;
    logic        mis;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    msrv32_load_request_unit #(.WAIT_LIMIT(16)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .load_req_in                 (load_req),
        .iadder_in                   (iadder),
        .funct3_in                   (funct3),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dmrd_req_out  (dmrd_req),
        .ms_riscv32_mp_data_hready_in(hready),
        .ms_riscv32_mp_dmdata_in     (dmdata),
        .load_data_out               (load_data),
        .load_valid_out              (valid),
        .load_busy_out               (busy),
        .misaligned_load_out         (mis),
        .access_fault_out            (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
        int          exp_kind;
        int          exp_lat;
        int          exp_busy;
        logic [31:0] exp_data;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One load: request presented for one edge, then observed for up to 40 cycles.
    // hready is raised in the (delay+1)-th REQ cycle.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input int delay, output int kind, output int lat, output int nbusy,
                            output logic [31:0] data, output logic [31:0] maddr, output int diff);
        kind = K_NONE; lat = 0; nbusy = 0; data = 32'd0; maddr = 32'd0; diff = 0;
        @(negedge clk);
        load_req = 1'b1; iadder = a; funct3 = f3; dmdata = d; hready = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            load_req = 1'b0;
            if (dmrd_req !== busy) diff++;
            if (busy) begin
                nbusy++;
                maddr = dmaddr;
            end
            if (valid || mis || fault) begin
                kind = valid ? K_VALID : (mis ? K_MIS : K_FAULT);
                lat  = c;
                data = load_data;
                break;
            end
            hready = busy && (nbusy >= delay + 1);
        end
        hready = 1'b0;
    endtask

    initial begin
        int kind, lat, nbusy, diff;
        logic [31:0] data, maddr;

        vecs.push_back('{"lb_b3",      3'b000, 32'h0000_1003, 32'h80FF_1234, 0,  K_VALID, 2,  1,  32'hFFFF_FF80, 32'h0000_1000});
        vecs.push_back('{"lhu_delay3", 3'b101, 32'h0000_2002, 32'hBEEF_0001, 3,  K_VALID, 5,  4,  32'h0000_BEEF, 32'h0000_2000});
        vecs.push_back('{"lh_h1",      3'b001, 32'h0000_2002, 32'hBEEF_0001, 0,  K_VALID, 2,  1,  32'hFFFF_BEEF, 32'h0000_2000});
        vecs.push_back('{"lbu_b2",     3'b100, 32'h0000_1002, 32'h80FF_1234, 1,  K_VALID, 3,  2,  32'h0000_00FF, 32'h0000_1000});
        vecs.push_back('{"lb_b1",      3'b000, 32'h0000_1001, 32'h80FF_1234, 0,  K_VALID, 2,  1,  32'h0000_0012, 32'h0000_1000});
        vecs.push_back('{"lh_h0",      3'b001, 32'h0000_4000, 32'h1234_8765, 2,  K_VALID, 4,  3,  32'hFFFF_8765, 32'h0000_4000});
        vecs.push_back('{"lhu_h0",     3'b101, 32'h0000_4000, 32'h1234_8765, 0,  K_VALID, 2,  1,  32'h0000_8765, 32'h0000_4000});
        vecs.push_back('{"lw",         3'b010, 32'h1223_3440, 32'h1234_5678, 0,  K_VALID, 2,  1,  32'h1234_5678, 32'h1223_3440});
        vecs.push_back('{"lw_misal",   3'b010, 32'hAAAA_AA0D, 32'h0000_0000, 0,  K_MIS,   1,  0,  32'h1234_5678, 32'h0});
        vecs.push_back('{"f3_011",     3'b011, 32'h0000_0000, 32'h0000_0000, 0,  K_FAULT, 1,  0,  32'h1234_5678, 32'h0});
        vecs.push_back('{"lh_misal",   3'b001, 32'h0000_0003, 32'h0000_0000, 0,  K_MIS,   1,  0,  32'h1234_5678, 32'h0});
        vecs.push_back('{"lw_misal2",  3'b010, 32'h0000_0002, 32'h0000_0000, 0,  K_MIS,   1,  0,  32'h1234_5678, 32'h0});
        vecs.push_back('{"f3_111",     3'b111, 32'h0000_0002, 32'h0000_0000, 0,  K_FAULT, 1,  0,  32'h1234_5678, 32'h0});
        vecs.push_back('{"lw_timeout", 3'b010, 32'h0000_0100, 32'h5555_5555, 99, K_FAULT, 17, 16, 32'h1234_5678, 32'h0000_0100});
        vecs.push_back('{"lw_last_ok", 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 15, K_VALID, 17, 16, 32'hCAFE_F00D, 32'h0000_0200});
        vecs.push_back('{"lb_pos",     3'b000, 32'h0000_0203, 32'h7F00_0000, 0,  K_VALID, 2,  1,  32'h0000_007F, 32'h0000_0200});

        // Reset values while reset is held
        #3;
        check("rst_dmaddr", dmaddr, 32'd0);
        check("rst_req",    {31'd0, dmrd_req}, 32'd0);
        check("rst_data",   load_data, 32'd0);
        check("rst_valid",  {31'd0, valid}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_mis",    {31'd0, mis}, 32'd0);
        check("rst_fault",  {31'd0, fault}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table of single loads
        foreach (vecs[i]) begin
            run_load(vecs[i].f3, vecs[i].addr, vecs[i].data, vecs[i].delay, kind, lat, nbusy, data, maddr, diff);
            $display("vec %0d %s: kind=%0d lat=%0d busy=%0d data=%h addr=%h", i, vecs[i].name, kind, lat, nbusy, data, maddr);
            check({vecs[i].name, "_kind"}, 32'(kind), 32'(vecs[i].exp_kind));
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_busy"}, 32'(nbusy), 32'(vecs[i].exp_busy));
            check({vecs[i].name, "_reqbusy"}, 32'(diff), 32'd0);
            check({vecs[i].name, "_data"}, data, vecs[i].exp_data);
            if (vecs[i].exp_busy > 0)
                check({vecs[i].name, "_addr"}, maddr, vecs[i].exp_maddr);
        end

        // Back-to-back: second LW accepted in RESP
        @(negedge clk);
        load_req = 1'b1; iadder = 32'h1223_3440; funct3 = 3'b010; dmdata = 32'h1234_5678; hready = 1'b0;
        @(negedge clk);  // cycle 1: REQ
        load_req = 1'b0;
        check("b2b_req1", {31'd0, dmrd_req}, 32'd1);
        check("b2b_addr1", dmaddr, 32'h1223_3440);
        hready = 1'b1;
        @(negedge clk);  // cycle 2: RESP, gap on the bus
        check("b2b_valid1", {31'd0, valid}, 32'd1);
        check("b2b_data1", load_data, 32'h1234_5678);
        check("b2b_gap", {31'd0, dmrd_req}, 32'd0);
        hready = 1'b0;
        load_req = 1'b1; iadder = 32'h0000_8884; dmdata = 32'h0000_0000;
        @(negedge clk);  // cycle 3: REQ for second load
        load_req = 1'b0;
        check("b2b_req2", {31'd0, dmrd_req}, 32'd1);
        check("b2b_addr2", dmaddr, 32'h0000_8884);
        check("b2b_hold", load_data, 32'h1234_5678);
        check("b2b_novalid", {31'd0, valid}, 32'd0);
        dmdata = 32'h9ABC_DEF0; hready = 1'b1;
        @(negedge clk);  // cycle 4: RESP
        hready = 1'b0;
        check("b2b_valid2", {31'd0, valid}, 32'd1);
        check("b2b_data2", load_data, 32'h9ABC_DEF0);
        $display("seq back_to_back: data=%h", load_data);

        // Reset asserted in the second REQ cycle
        @(negedge clk);
        load_req = 1'b1; iadder = 32'h0000_0300; funct3 = 3'b010; dmdata = 32'h1111_2222; hready = 1'b0;
        @(negedge clk);  // REQ cycle 1
        load_req = 1'b0;
        @(negedge clk);  // REQ cycle 2
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_req",   {31'd0, dmrd_req}, 32'd0);
        check("mr_busy",  {31'd0, busy}, 32'd0);
        check("mr_valid", {31'd0, valid}, 32'd0);
        check("mr_fault", {31'd0, fault}, 32'd0);
        check("mr_mis",   {31'd0, mis}, 32'd0);
        check("mr_data",  load_data, 32'd0);
        check("mr_addr",  dmaddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mr_idle_busy",  {31'd0, busy}, 32'd0);
        check("mr_idle_pulse", {29'd0, valid, fault, mis}, 32'd0);
        run_load(3'b010, 32'h0000_0304, 32'h0BAD_F00D, 0, kind, lat, nbusy, data, maddr, diff);
        $display("seq reset_mid_req: kind=%0d lat=%0d data=%h", kind, lat, data);
        check("mr_after_kind", 32'(kind), 32'(K_VALID));
        check("mr_after_lat",  32'(lat), 32'd2);
        check("mr_after_data", data, 32'h0BAD_F00D);
        check("mr_after_addr", maddr, 32'h0000_0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
